// File: rtl/mini_alu_core.sv
// mini_alu_core
// Two-stage fetch/execute core. It reads instructions from an external
// combinational ROM and has an internal register file. An iterative signed
// multiplier writes RL/RH and stalls the pipeline while it runs. The core
// drives the board LEDs.
//
// Ports:
//   Clock        - single clock, rising edge
//   Reset        - asynchronous, active-high
//   iRun         - 1 advances the pipeline, 0 freezes every register
//   oIP          - instruction address presented to the ROM
//   iInstruction - ROM word for oIP, valid in the same cycle
//   oLed         - LED register
//   oBusy        - high while SMUL iterates (pipeline stalled)
//
// Instruction format: [op 4][dst ADDR_W][src1 ADDR_W][src0 ADDR_W].
// Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 SMUL, 4 STO, 5 BLE, 6 JMP, 7 LED.
// Any other opcode behaves as NOP.
//
// Build option: defining MINI_ALU_SAT_EN makes ADD/SUB saturate instead of wrap.
module mini_alu_core #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 254,
    parameter int IP_W    = 16,
    parameter int LED_W   = 8,
    localparam int INSTR_W = 4 + 3 * ADDR_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iRun,
    output logic [IP_W-1:0]    oIP,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic [LED_W-1:0]   oLed,
    output logic               oBusy
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SMUL = 4'd3;
    localparam logic [3:0] OP_STO  = 4'd4;
    localparam logic [3:0] OP_BLE  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_LED  = 4'd7;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [ADDR_W-1:0] ADDR_RL = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] ADDR_RH = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {EXEC, MUL, FIN} state_t;

    state_t                state_q, state_d;
    logic [IP_W-1:0]       ip_q, ip_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic [DATA_W-1:0]     rl_q, rl_d, rh_q, rh_d;
    logic [DATA_W-1:0]     mcand_q, mcand_d;
    logic [2*DATA_W-1:0]   prod_q, prod_d;
    logic                  sign_q, sign_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_W-1:0]     regs_q [DEPTH];

    logic                  regWe;
    logic [DATA_W-1:0]     regWdata;

    logic [3:0]            op;
    logic [ADDR_W-1:0]     dst, s1Addr, s0Addr;
    logic [DATA_W-1:0]     imm, aVal, bVal, absA, absB, addRes, subRes;
    logic [2*DATA_W-1:0]   prodSigned;

    assign op     = instr_q[INSTR_W-1 -: 4];
    assign dst    = instr_q[3*ADDR_W-1 -: ADDR_W];
    assign s1Addr = instr_q[2*ADDR_W-1 -: ADDR_W];
    assign s0Addr = instr_q[ADDR_W-1:0];
    assign imm    = DATA_W'(instr_q[2*ADDR_W-1:0]);

    // The two addresses at the top of the address space read the multiplier result registers.
    function automatic logic [DATA_W-1:0] readReg(input logic [ADDR_W-1:0] addr);
        if (addr == ADDR_RL)      return rl_q;
        else if (addr == ADDR_RH) return rh_q;
        else if (addr < DEPTH_A)  return regs_q[addr];
        else                      return '0;
    endfunction

    // One shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB (held in the low half) is set, then shift the whole product right.
    function automatic logic [2*DATA_W-1:0] mulStep(input logic [2*DATA_W-1:0] p,
                                                    input logic [DATA_W-1:0]   mc);
        logic [DATA_W:0] upper;
        upper = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, mc} : '0);
        return {upper, p[DATA_W-1:1]};
    endfunction

    assign aVal = readReg(s1Addr);
    assign bVal = readReg(s0Addr);
    // Unsigned magnitude; -2**(DATA_W-1) maps onto the same bit pattern, which is its correct magnitude.
    assign absA = aVal[DATA_W-1] ? -aVal : aVal;
    assign absB = bVal[DATA_W-1] ? -bVal : bVal;
    assign prodSigned = sign_q ? -prod_q : prod_q;

`ifdef MINI_ALU_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic [DATA_W:0] addWide, subWide;
    assign addWide = {aVal[DATA_W-1], aVal} + {bVal[DATA_W-1], bVal};
    assign subWide = {aVal[DATA_W-1], aVal} - {bVal[DATA_W-1], bVal};
    // Overflow shows up as the two top bits of the widened result disagreeing.
    assign addRes = (addWide[DATA_W] != addWide[DATA_W-1])
                  ? (addWide[DATA_W] ? SAT_MIN : SAT_MAX) : addWide[DATA_W-1:0];
    assign subRes = (subWide[DATA_W] != subWide[DATA_W-1])
                  ? (subWide[DATA_W] ? SAT_MIN : SAT_MAX) : subWide[DATA_W-1:0];
`else
    assign addRes = aVal + bVal;
    assign subRes = aVal - bVal;
`endif

    // Next-state logic for the pipeline and multiplier FSM. With iRun low, every _d keeps its _q value.
    // The first shift-add step happens on the EXEC->MUL edge, so MUL runs DATA_W-1 cycles.
    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        instr_d  = instr_q;
        led_d    = led_q;
        rl_d     = rl_q;
        rh_d     = rh_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        count_d  = count_q;
        regWe    = 1'b0;
        regWdata = '0;
        oBusy    = 1'b0;
        case (state_q)
            EXEC: begin
                if (op == OP_SMUL) begin
                    oBusy = 1'b1;
                    if (iRun) begin
                        mcand_d = absA;
                        prod_d  = mulStep({{DATA_W{1'b0}}, absB}, absA);
                        sign_d  = aVal[DATA_W-1] ^ bVal[DATA_W-1];
                        count_d = CNT_W'(DATA_W - 1);
                        state_d = MUL;
                    end
                end else if (iRun) begin
                    ip_d    = ip_q + 1'b1;
                    instr_d = iInstruction;
                    case (op)
                        OP_ADD: begin regWe = 1'b1; regWdata = addRes; end
                        OP_SUB: begin regWe = 1'b1; regWdata = subRes; end
                        OP_STO: begin regWe = 1'b1; regWdata = imm;    end
                        OP_BLE: begin
                            if ($signed(aVal) <= $signed(bVal)) begin
                                ip_d    = IP_W'(dst);
                                instr_d = '0;
                            end
                        end
                        OP_JMP: begin
                            ip_d    = IP_W'(dst);
                            instr_d = '0;
                        end
                        OP_LED: led_d = aVal[LED_W-1:0];
                        default: ;
                    endcase
                end
            end
            MUL: begin
                oBusy = 1'b1;
                if (iRun) begin
                    prod_d  = mulStep(prod_q, mcand_q);
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) state_d = FIN;
                end
            end
            FIN: begin
                if (iRun) begin
                    {rh_d, rl_d} = prodSigned;
                    ip_d    = ip_q + 1'b1;
                    instr_d = iInstruction;
                    state_d = EXEC;
                end
            end
            default: state_d = EXEC;
        endcase
    end

    // Pipeline, LED, multiplier and FSM registers; a reset aborts any multiply in progress.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= EXEC;
            ip_q    <= '0;
            instr_q <= '0;
            led_q   <= '0;
            rl_q    <= '0;
            rh_q    <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            sign_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            instr_q <= instr_d;
            led_q   <= led_d;
            rl_q    <= rl_d;
            rh_q    <= rh_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            sign_q  <= sign_d;
            count_q <= count_d;
        end
    end

    // Register file is not reset. Writes to RL/RH or unmapped addresses fall outside DEPTH and are dropped.
    always_ff @(posedge Clock) begin
        if (regWe && (dst < DEPTH_A)) regs_q[dst] <= regWdata;
    end

    assign oIP  = ip_q;
    assign oLed = led_q;

endmodule

// File: tb/tb_mini_alu_core.sv
// Testbench for mini_alu_core with DATA_W=16, ADDR_W=8, LED_W=8.
// The ROM is modelled as an array indexed by the low byte of oIP.
module tb_mini_alu_core;

    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, SMUL = 4'd3,
                           STO = 4'd4, BLE = 4'd5, JMP = 4'd6, LED = 4'd7;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iRun  = 1'b1;
    logic [15:0] oIP;
    logic [27:0] iInstruction;
    logic [7:0]  oLed;
    logic        oBusy;

    logic [27:0] rom [256];
    int errors = 0;
    int checks = 0;

    mini_alu_core dut (
        .Clock(Clock), .Reset(Reset), .iRun(iRun), .oIP(oIP),
        .iInstruction(iInstruction), .oLed(oLed), .oBusy(oBusy)
    );

    assign iInstruction = rom[oIP[7:0]];

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [27:0] enc(logic [3:0] op, logic [7:0] d, logic [7:0] s1, logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = enc(NOP, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic doReset();
        @(negedge Clock);
        Reset = 1'b1;
        iRun  = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        clearRom();
        rom[0] = enc(STO, 8'd1, 8'h00, 8'h05);
        doReset();
        checks++; if (oIP !== 16'd0) begin errors++; $display("[TB] FAIL reset_ip: got %h expected %h", oIP, 16'd0); end
        checks++; if (oLed !== 8'h00) begin errors++; $display("[TB] FAIL reset_led: got %h expected %h", oLed, 8'h00); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected %b", oBusy, 1'b0); end
        tick();
        checks++; if (oIP !== 16'd1) begin errors++; $display("[TB] FAIL first_fetch_ip: got %h expected %h", oIP, 16'd1); end
        checks++; if (dut.instr_q !== rom[0]) begin errors++; $display("[TB] FAIL first_fetch_instr: got %h expected %h", dut.instr_q, rom[0]); end
    endtask

    task automatic test_back_to_back();
        clearRom();
        rom[0] = enc(STO, 8'd1, 8'h00, 8'h05);
        rom[1] = enc(STO, 8'd2, 8'h00, 8'h07);
        rom[2] = enc(ADD, 8'd3, 8'd2, 8'd1);
        rom[3] = enc(LED, 8'd0, 8'd3, 8'd0);
        doReset();
        repeat (4) tick();
        checks++; if (oLed !== 8'h00) begin errors++; $display("[TB] FAIL b2b_led_early: got %h expected %h", oLed, 8'h00); end
        tick();
        checks++; if (oLed !== 8'h0C) begin errors++; $display("[TB] FAIL b2b_led: got %h expected %h", oLed, 8'h0C); end
        checks++; if (oIP !== 16'd5) begin errors++; $display("[TB] FAIL b2b_ip: got %h expected %h", oIP, 16'd5); end
    endtask

    task automatic test_smul();
        int busyCount = 0;
        int n = 0;
        clearRom();
        rom[0] = enc(STO, 8'd1, 8'hFF, 8'hFD);
        rom[1] = enc(STO, 8'd2, 8'h03, 8'hE8);
        rom[2] = enc(SMUL, 8'd0, 8'd2, 8'd1);
        rom[3] = enc(LED, 8'd0, 8'hFE, 8'd0);
        rom[4] = enc(LED, 8'd0, 8'hFF, 8'd0);
        doReset();
        repeat (3) tick();
        checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL smul_busy_start: got %b expected %b", oBusy, 1'b1); end
        while (oBusy === 1'b1 && n < 60) begin
            busyCount++;
            checks++; if (oIP !== 16'd3) begin errors++; $display("[TB] FAIL smul_ip_frozen: got %h expected %h", oIP, 16'd3); end
            if (busyCount == 5) begin
                iRun = 1'b0;
                repeat (3) tick();
                checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL smul_pause_busy: got %b expected %b", oBusy, 1'b1); end
                iRun = 1'b1;
            end
            tick();
            n++;
        end
        checks++; if (busyCount !== 16) begin errors++; $display("[TB] FAIL smul_busy_cycles: got %0d expected %0d", busyCount, 16); end
        checks++; if (oIP !== 16'd3) begin errors++; $display("[TB] FAIL smul_fin_ip: got %h expected %h", oIP, 16'd3); end
        tick();
        checks++; if (dut.rl_q !== 16'hF448) begin errors++; $display("[TB] FAIL smul_rl: got %h expected %h", dut.rl_q, 16'hF448); end
        checks++; if (dut.rh_q !== 16'hFFFF) begin errors++; $display("[TB] FAIL smul_rh: got %h expected %h", dut.rh_q, 16'hFFFF); end
        checks++; if (oIP !== 16'd4) begin errors++; $display("[TB] FAIL smul_resume_ip: got %h expected %h", oIP, 16'd4); end
        tick();
        checks++; if (oLed !== 8'h48) begin errors++; $display("[TB] FAIL smul_led_rl: got %h expected %h", oLed, 8'h48); end
        tick();
        checks++; if (oLed !== 8'hFF) begin errors++; $display("[TB] FAIL smul_led_rh: got %h expected %h", oLed, 8'hFF); end
    endtask

    task automatic test_smul_min_reset();
        int n = 0;
        clearRom();
        rom[0] = enc(STO, 8'd1, 8'h80, 8'h00);
        rom[1] = enc(SMUL, 8'd0, 8'd1, 8'd1);
        rom[2] = enc(JMP, 8'd0, 8'd0, 8'd0);
        doReset();
        repeat (2) tick();
        while (oBusy === 1'b1 && n < 40) begin tick(); n++; end
        tick();
        checks++; if (dut.rh_q !== 16'h4000) begin errors++; $display("[TB] FAIL min_rh: got %h expected %h", dut.rh_q, 16'h4000); end
        checks++; if (dut.rl_q !== 16'h0000) begin errors++; $display("[TB] FAIL min_rl: got %h expected %h", dut.rl_q, 16'h0000); end
        tick();
        checks++; if (oIP !== 16'd0) begin errors++; $display("[TB] FAIL jmp_ip: got %h expected %h", oIP, 16'd0); end
        n = 0;
        while (oBusy !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL min_busy_again: got %b expected %b", oBusy, 1'b1); end
        repeat (5) tick();
        Reset = 1'b1;
        #1;
        checks++; if (dut.rl_q !== 16'h0000) begin errors++; $display("[TB] FAIL abort_rl: got %h expected %h", dut.rl_q, 16'h0000); end
        checks++; if (dut.rh_q !== 16'h0000) begin errors++; $display("[TB] FAIL abort_rh: got %h expected %h", dut.rh_q, 16'h0000); end
        checks++; if (oIP !== 16'd0) begin errors++; $display("[TB] FAIL abort_ip: got %h expected %h", oIP, 16'd0); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected %b", oBusy, 1'b0); end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_branch();
        clearRom();
        rom[0]  = enc(STO, 8'd1, 8'h00, 8'h02);
        rom[1]  = enc(STO, 8'd2, 8'h00, 8'h02);
        rom[2]  = enc(STO, 8'd5, 8'h00, 8'h33);
        rom[10] = enc(BLE, 8'd3, 8'd1, 8'd2);
        rom[11] = enc(LED, 8'd0, 8'd5, 8'd0);
        doReset();
        repeat (11) tick();
        checks++; if (oIP !== 16'd11) begin errors++; $display("[TB] FAIL ble_pre_ip: got %h expected %h", oIP, 16'd11); end
        tick();
        checks++; if (oIP !== 16'd3) begin errors++; $display("[TB] FAIL ble_taken_ip: got %h expected %h", oIP, 16'd3); end
        tick();
        checks++; if (oLed !== 8'h00) begin errors++; $display("[TB] FAIL ble_squash_led: got %h expected %h", oLed, 8'h00); end
        checks++; if (oIP !== 16'd4) begin errors++; $display("[TB] FAIL ble_target_ip: got %h expected %h", oIP, 16'd4); end
        rom[0] = enc(STO, 8'd1, 8'h00, 8'h03);
        doReset();
        repeat (12) tick();
        checks++; if (oIP !== 16'd12) begin errors++; $display("[TB] FAIL ble_fall_ip: got %h expected %h", oIP, 16'd12); end
        tick();
        checks++; if (oLed !== 8'h33) begin errors++; $display("[TB] FAIL ble_fall_led: got %h expected %h", oLed, 8'h33); end
        rom[0] = enc(STO, 8'd1, 8'hFF, 8'hFF);
        doReset();
        repeat (12) tick();
        checks++; if (oIP !== 16'd3) begin errors++; $display("[TB] FAIL ble_signed_ip: got %h expected %h", oIP, 16'd3); end
    endtask

    task automatic test_overflow_freeze();
        logic [15:0] expSum;
        logic [7:0]  expLed;
`ifdef MINI_ALU_SAT_EN
        expSum = 16'h7FFF;
`else
        expSum = 16'h8000;
`endif
        expLed = expSum[7:0];
        clearRom();
        rom[0] = enc(STO, 8'd1, 8'h7F, 8'hFF);
        rom[1] = enc(STO, 8'd2, 8'h00, 8'h01);
        rom[2] = enc(ADD, 8'd3, 8'd1, 8'd2);
        rom[3] = enc(LED, 8'd0, 8'd3, 8'd0);
        rom[4] = enc(SUB, 8'd6, 8'd2, 8'd1);
        rom[5] = enc(LED, 8'd0, 8'd6, 8'd0);
        doReset();
        repeat (4) tick();
        checks++; if (dut.regs_q[3] !== expSum) begin errors++; $display("[TB] FAIL add_ovf: got %h expected %h", dut.regs_q[3], expSum); end
        tick();
        checks++; if (oLed !== expLed) begin errors++; $display("[TB] FAIL add_led: got %h expected %h", oLed, expLed); end
        tick();
        checks++; if (dut.regs_q[6] !== 16'h8002) begin errors++; $display("[TB] FAIL sub_res: got %h expected %h", dut.regs_q[6], 16'h8002); end
        iRun = 1'b0;
        repeat (4) tick();
        checks++; if (oIP !== 16'd6) begin errors++; $display("[TB] FAIL freeze_ip: got %h expected %h", oIP, 16'd6); end
        checks++; if (oLed !== expLed) begin errors++; $display("[TB] FAIL freeze_led: got %h expected %h", oLed, expLed); end
        iRun = 1'b1;
        tick();
        checks++; if (oLed !== 8'h02) begin errors++; $display("[TB] FAIL resume_led: got %h expected %h", oLed, 8'h02); end
        checks++; if (oIP !== 16'd7) begin errors++; $display("[TB] FAIL resume_ip: got %h expected %h", oIP, 16'd7); end
    endtask

    initial begin
        clearRom();
        test_reset();
        test_back_to_back();
        test_smul();
        test_smul_min_reset();
        test_branch();
        test_overflow_freeze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
